ahb_arbiter: RTL and testbench



---
 rtl/common_types_pkg.sv | 44 ++++
 rtl/ahb_arb_hold.sv | 32 +++
 rtl/ahb_arbiter.sv | 146 ++++++++++++++
 tb/tb_ahb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared bus types for the core: word/transfer encodings plus the
// manager and data-phase-owner enums used by the AHB-Lite arbiter.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        MGR_DATA  = 1'b0,
        MGR_FETCH = 1'b1
    } ahb_mgr_t;

    typedef enum logic [1:0] {
        DP_NONE = 2'b00,
        DP_M0   = 2'b01,
        DP_M1   = 2'b10
    } dp_owner_t;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Data-phase owner code for a granted manager.
    function automatic dp_owner_t mgr_to_dp(input ahb_mgr_t m);
        return (m == MGR_FETCH) ? DP_M1 : DP_M0;
    endfunction

    // HREADY seen by one manager: the granted one follows the bus, a stalled
    // requester is held off, an idle one only waits on its own data phase.
    function automatic logic mgr_hready(input logic granted, input logic req,
                                        input logic owns_dp, input logic bus_ready);
        if (granted) return bus_ready;
        if (req) return 1'b0;
        if (owns_dp) return bus_ready;
        return 1'b1;
    endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-manager response hold buffer: keeps a completed data-phase response
// for a manager whose next address is still waiting for the bus.
module ahb_arb_hold
    import common_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] s_hrdata,
    input  logic        s_hresp,
    output logic        hold_vld,
    output logic [31:0] hold_rdata,
    output logic        hold_resp
);

    // Latch the response on capture; drop it once the manager owns the bus again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld   <= 1'b0;
            hold_rdata <= '0;
            hold_resp  <= HRESP_OKAY;
        end else if (capture) begin
            hold_vld   <= 1'b1;
            hold_rdata <= s_hrdata;
            hold_resp  <= s_hresp;
        end else if (clear) begin
            hold_vld   <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-manager AHB-Lite arbiter: round-robin address-phase grant with burst
// lock, data-phase ownership tracking for hwdata/response routing, and a
// response hold buffer per manager.
// Handshake: a manager's address/data beat completes on a rising edge where
// its mN_hready is 1; the bus side completes when s_hready is 1.
module ahb_arbiter
    import common_types_pkg::*;
#(
    parameter bit DEFAULT_GNT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,
    output logic [31:0] s_haddr,
    output logic [1:0]  s_htrans,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [2:0]  s_hburst,
    output logic [31:0] s_hwdata,
    input  logic [31:0] s_hrdata,
    input  logic        s_hready,
    input  logic        s_hresp
);

    htrans_t   m0_trans, m1_trans, g_trans;
    logic      m0_req, m1_req, other_req, g_lock;
    ahb_mgr_t  gnt_q, gnt_d;
    dp_owner_t dp_q, dp_d;
    logic      hold0_vld, hold1_vld, hold0_resp, hold1_resp;
    word_t     hold0_rdata, hold1_rdata;

    assign m0_trans = htrans_t'(m0_htrans);
    assign m1_trans = htrans_t'(m1_htrans);
    assign m0_req   = (m0_trans != HTRANS_IDLE);
    assign m1_req   = (m1_trans != HTRANS_IDLE);

    // Address phase of the granted manager goes to the multiplexor.
    always_comb begin
        if (gnt_q == MGR_FETCH) begin
            s_haddr  = m1_haddr;
            g_trans  = m1_trans;
            s_hwrite = m1_hwrite;
            s_hsize  = m1_hsize;
            s_hburst = m1_hburst;
        end else begin
            s_haddr  = m0_haddr;
            g_trans  = m0_trans;
            s_hwrite = m0_hwrite;
            s_hsize  = m0_hsize;
            s_hburst = m0_hburst;
        end
    end

    assign s_htrans  = g_trans;
    assign other_req = (gnt_q == MGR_DATA) ? m1_req : m0_req;
    // A burst's opening NONSEQ locks as well, otherwise the first beat of a
    // freshly granted burst could be followed by a switch.
    assign g_lock = (g_trans == HTRANS_SEQ) || (g_trans == HTRANS_BUSY) ||
                    ((g_trans == HTRANS_NONSEQ) && (s_hburst != HBURST_SINGLE));

    // Next grant and data-phase owner; both frozen during wait states.
    always_comb begin
        gnt_d = gnt_q;
        dp_d  = dp_q;
        if (s_hready) begin
            if (!g_lock && other_req)
                gnt_d = (gnt_q == MGR_DATA) ? MGR_FETCH : MGR_DATA;
            if ((g_trans == HTRANS_NONSEQ) || (g_trans == HTRANS_SEQ))
                dp_d = mgr_to_dp(gnt_q);
            else
                dp_d = DP_NONE;
        end
    end

    // Grant and data-phase owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= ahb_mgr_t'(DEFAULT_GNT);
            dp_q  <= DP_NONE;
        end else begin
            gnt_q <= gnt_d;
            dp_q  <= dp_d;
        end
    end

    // Write data follows the data-phase owner; quiet when nobody owns it.
    always_comb begin
        case (dp_q)
            DP_M0:   s_hwdata = m0_hwdata;
            DP_M1:   s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    ahb_arb_hold u_hold0 (
        .clk        (clk),
        .rst        (rst),
        .capture    (s_hready && (dp_q == DP_M0) && m0_req && (gnt_q != MGR_DATA)),
        .clear      (s_hready && (gnt_q == MGR_DATA)),
        .s_hrdata   (s_hrdata),
        .s_hresp    (s_hresp),
        .hold_vld   (hold0_vld),
        .hold_rdata (hold0_rdata),
        .hold_resp  (hold0_resp)
    );

    ahb_arb_hold u_hold1 (
        .clk        (clk),
        .rst        (rst),
        .capture    (s_hready && (dp_q == DP_M1) && m1_req && (gnt_q != MGR_FETCH)),
        .clear      (s_hready && (gnt_q == MGR_FETCH)),
        .s_hrdata   (s_hrdata),
        .s_hresp    (s_hresp),
        .hold_vld   (hold1_vld),
        .hold_rdata (hold1_rdata),
        .hold_resp  (hold1_resp)
    );

    // Ready and response per manager; an error reaches only the data-phase owner.
    always_comb begin
        m0_hready = mgr_hready(gnt_q == MGR_DATA, m0_req, dp_q == DP_M0, s_hready);
        m1_hready = mgr_hready(gnt_q == MGR_FETCH, m1_req, dp_q == DP_M1, s_hready);
        m0_hrdata = hold0_vld ? hold0_rdata : s_hrdata;
        m1_hrdata = hold1_vld ? hold1_rdata : s_hrdata;
        m0_hresp  = hold0_vld ? hold0_resp : ((dp_q == DP_M0) ? s_hresp : HRESP_OKAY);
        m1_hresp  = hold1_vld ? hold1_resp : ((dp_q == DP_M1) ? s_hresp : HRESP_OKAY);
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: the bench plays both managers and the
// multiplexor; expected addresses/data go into exp_q as stimulus is driven.
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE  = 2'b00;
    localparam logic [1:0] T_NS    = 2'b10;
    localparam logic [1:0] T_SEQ   = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;

    logic        clk, rst;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite, m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_hready, s_hresp;
    logic [2:0]  s_hsize, s_hburst;

    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int vectors, miscompares;

    ahb_arbiter #(.DEFAULT_GNT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
        .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
        .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] bu);
        m0_htrans = tr; m0_haddr = a; m0_hwrite = wr; m0_hburst = bu; m0_hsize = 3'b010;
    endtask

    task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] bu);
        m1_htrans = tr; m1_haddr = a; m1_hwrite = wr; m1_hburst = bu; m1_hsize = 3'b010;
    endtask

    task automatic idle_all();
        drive_m0(T_IDLE, m0_haddr, 1'b0, B_SINGLE);
        drive_m1(T_IDLE, m1_haddr, 1'b0, B_SINGLE);
        s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
    endtask

    task automatic test_reset();
        step(); step();
        drive_m0(T_IDLE, 32'h100, 1'b0, B_SINGLE);
        drive_m1(T_IDLE, 32'h200, 1'b0, B_SINGLE);
        @(negedge clk);
        vectors++; if (s_haddr !== 32'h100) begin miscompares++; $display("FAIL rst_haddr got %h exp %h", s_haddr, 32'h100); end
        vectors++; if (s_hwdata !== 32'h0) begin miscompares++; $display("FAIL rst_hwdata got %h exp %h", s_hwdata, 32'h0); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL rst_m0_hready got %b exp 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL rst_m1_hready got %b exp 1", m1_hready); end
        vectors++; if (m0_hresp !== 1'b0) begin miscompares++; $display("FAIL rst_m0_hresp got %b exp 0", m0_hresp); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_park();
        drive_m0(T_NS, 32'h10, 1'b0, B_SINGLE);
        exp_q.push_back(32'h10);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL park_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL park_m0_hready got %b exp 1", m0_hready); end
        step();
        drive_m0(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        s_hrdata = 32'h1111_1111;
        exp_q.push_back(32'h1111_1111);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (m0_hrdata !== exp_w) begin miscompares++; $display("FAIL park_rdata got %h exp %h", m0_hrdata, exp_w); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_contention();
        exp_q.push_back(32'h20); exp_q.push_back(32'h30);
        exp_q.push_back(32'h24); exp_q.push_back(32'h34);
        // A: both request, m0 parked and accepted
        drive_m0(T_NS, 32'h20, 1'b0, B_SINGLE);
        drive_m1(T_NS, 32'h30, 1'b0, B_SINGLE);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL cont_a_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL cont_a_m0_hready got %b exp 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("FAIL cont_a_m1_hready got %b exp 0", m1_hready); end
        step();
        // B: m1 accepted, m0 next address stalled
        drive_m0(T_NS, 32'h24, 1'b0, B_SINGLE);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL cont_b_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL cont_b_m1_hready got %b exp 1", m1_hready); end
        vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("FAIL cont_b_m0_hready got %b exp 0", m0_hready); end
        step();
        // C: back to m0
        drive_m1(T_NS, 32'h34, 1'b0, B_SINGLE);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL cont_c_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("FAIL cont_c_m1_hready got %b exp 0", m1_hready); end
        step();
        // D: back to m1
        drive_m0(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL cont_d_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL cont_d_m1_hready got %b exp 1", m1_hready); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_burst();
        // m1 is parked here; m0 competes throughout the INCR4
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        exp_q.push_back(32'h200);
        drive_m0(T_NS, 32'h200, 1'b0, B_SINGLE);
        for (int i = 0; i < 4; i++) begin
            drive_m1((i == 0) ? T_NS : T_SEQ, 32'h100 + 32'(i * 4), 1'b0, B_INCR4);
            @(negedge clk);
            exp_w = exp_q.pop_front();
            vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL burst_beat%0d_haddr got %h exp %h", i, s_haddr, exp_w); end
            vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL burst_beat%0d_m1_hready got %b exp 1", i, m1_hready); end
            vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("FAIL burst_beat%0d_m0_hready got %b exp 0", i, m0_hready); end
            step();
        end
        drive_m1(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        step();
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_haddr !== exp_w) begin miscompares++; $display("FAIL burst_m0_haddr got %h exp %h", s_haddr, exp_w); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL burst_m0_hready got %b exp 1", m0_hready); end
        step();
        idle_all();
        step(); step();
    endtask

    task automatic test_hold();
        drive_m0(T_NS, 32'h300, 1'b0, B_SINGLE);
        drive_m1(T_NS, 32'h400, 1'b0, B_SINGLE);
        step();
        // m0 data completes while its next address waits behind m1
        drive_m0(T_NS, 32'h304, 1'b0, B_SINGLE);
        s_hrdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("FAIL hold_stall_m0_hready got %b exp 0", m0_hready); end
        step();
        drive_m1(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        s_hrdata = 32'h1234_5678;
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL hold_m0_hready got %b exp 1", m0_hready); end
        vectors++; if (m0_hrdata !== exp_w) begin miscompares++; $display("FAIL hold_m0_rdata got %h exp %h", m0_hrdata, exp_w); end
        vectors++; if (m1_hrdata !== 32'h1234_5678) begin miscompares++; $display("FAIL hold_m1_rdata got %h exp %h", m1_hrdata, 32'h1234_5678); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL hold_m1_hready got %b exp 1", m1_hready); end
        step();
        drive_m0(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        s_hrdata = 32'hCAFE_0000;
        @(negedge clk);
        vectors++; if (m0_hrdata !== 32'hCAFE_0000) begin miscompares++; $display("FAIL hold_after_rdata got %h exp %h", m0_hrdata, 32'hCAFE_0000); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_write_routing();
        m0_hwdata = 32'h5A5A_5A5A;
        m1_hwdata = 32'hA5A5_A5A5;
        drive_m1(T_NS, 32'h0002_0004, 1'b1, B_SINGLE);
        exp_q.push_back(32'hA5A5_A5A5);
        @(negedge clk);
        vectors++; if (s_hwdata !== 32'h0) begin miscompares++; $display("FAIL wr_w1_hwdata got %h exp %h", s_hwdata, 32'h0); end
        step();
        drive_m0(T_NS, 32'h500, 1'b0, B_SINGLE);
        @(negedge clk);
        vectors++; if (s_haddr !== 32'h0002_0004) begin miscompares++; $display("FAIL wr_haddr got %h exp %h", s_haddr, 32'h0002_0004); end
        vectors++; if (s_hwrite !== 1'b1) begin miscompares++; $display("FAIL wr_hwrite got %b exp 1", s_hwrite); end
        vectors++; if (s_hwdata !== 32'h0) begin miscompares++; $display("FAIL wr_w2_hwdata got %h exp %h", s_hwdata, 32'h0); end
        vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("FAIL wr_m0_stall got %b exp 0", m0_hready); end
        step();
        drive_m1(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        vectors++; if (s_hwdata !== exp_w) begin miscompares++; $display("FAIL wr_dp_hwdata got %h exp %h", s_hwdata, exp_w); end
        step();
        drive_m0(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        @(negedge clk);
        vectors++; if (s_hwdata !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL wr_m0dp_hwdata got %h exp %h", s_hwdata, 32'h5A5A_5A5A); end
        step();
        @(negedge clk);
        vectors++; if (s_hwdata !== 32'h0) begin miscompares++; $display("FAIL wr_none_hwdata got %h exp %h", s_hwdata, 32'h0); end
        step();
    endtask

    task automatic test_error_reset();
        drive_m0(T_NS, 32'h600, 1'b0, B_SINGLE);
        step();
        // two-cycle ERROR on m0's data phase, m1 starts requesting
        drive_m0(T_IDLE, 32'h0, 1'b0, B_SINGLE);
        drive_m1(T_NS, 32'h700, 1'b0, B_SINGLE);
        s_hready = 1'b0; s_hresp = 1'b1;
        @(negedge clk);
        vectors++; if (m0_hresp !== 1'b1) begin miscompares++; $display("FAIL err1_m0_hresp got %b exp 1", m0_hresp); end
        vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("FAIL err1_m0_hready got %b exp 0", m0_hready); end
        vectors++; if (m1_hresp !== 1'b0) begin miscompares++; $display("FAIL err1_m1_hresp got %b exp 0", m1_hresp); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("FAIL err1_m1_hready got %b exp 0", m1_hready); end
        step();
        s_hready = 1'b1;
        @(negedge clk);
        vectors++; if (m0_hresp !== 1'b1) begin miscompares++; $display("FAIL err2_m0_hresp got %b exp 1", m0_hresp); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL err2_m0_hready got %b exp 1", m0_hready); end
        vectors++; if (m1_hresp !== 1'b0) begin miscompares++; $display("FAIL err2_m1_hresp got %b exp 0", m1_hresp); end
        vectors++; if (s_htrans !== T_IDLE) begin miscompares++; $display("FAIL err2_frozen_htrans got %b exp %b", s_htrans, T_IDLE); end
        step();
        s_hresp = 1'b0;
        @(negedge clk);
        vectors++; if (s_haddr !== 32'h700) begin miscompares++; $display("FAIL err_m1_haddr got %h exp %h", s_haddr, 32'h700); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL err_m1_hready got %b exp 1", m1_hready); end
        step();
        // INCR4 write on m1, reset in the middle of it
        m1_hwdata = 32'h7777_0000;
        drive_m1(T_NS, 32'h800, 1'b1, B_INCR4);
        step();
        drive_m1(T_SEQ, 32'h804, 1'b1, B_INCR4);
        drive_m0(T_IDLE, 32'h900, 1'b0, B_SINGLE);
        @(negedge clk);
        vectors++; if (s_hwdata !== 32'h7777_0000) begin miscompares++; $display("FAIL burst_wr_hwdata got %h exp %h", s_hwdata, 32'h7777_0000); end
        vectors++; if (s_haddr !== 32'h804) begin miscompares++; $display("FAIL burst_wr_haddr got %h exp %h", s_haddr, 32'h804); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (s_haddr !== 32'h900) begin miscompares++; $display("FAIL rstmid_haddr got %h exp %h", s_haddr, 32'h900); end
        vectors++; if (s_hwdata !== 32'h0) begin miscompares++; $display("FAIL rstmid_hwdata got %h exp %h", s_hwdata, 32'h0); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("FAIL rstmid_m1_hready got %b exp 0", m1_hready); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("FAIL rstmid_m0_hready got %b exp 1", m0_hready); end
        idle_all();
        step(); step();
        rst = 1'b0;
        step();
        @(negedge clk);
        vectors++; if (s_haddr !== 32'h900) begin miscompares++; $display("FAIL post_rst_haddr got %h exp %h", s_haddr, 32'h900); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("FAIL post_rst_m1_hready got %b exp 1", m1_hready); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        m0_haddr = '0; m1_haddr = '0; m0_hwdata = '0; m1_hwdata = '0;
        m0_hsize = 3'b010; m1_hsize = 3'b010;
        idle_all();
        test_reset();
        test_park();
        test_contention();
        test_burst();
        test_hold();
        test_write_routing();
        test_error_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
